seg7_scan: RTL and testbench
============================

# seg7_scan

Multiplexed common-anode seven-segment display driver that consumes the slow square wave from the 1 kHz clock-enable divider. It steps one digit per rising edge of that wave. It shows a hex value committed through a load/ack handshake, and commits only at frame boundaries so a displayed number never tears. It sits between the result register of the datapath and the board display pins.

## Interface
- DIGITS, 4, number of display digits (2..8)
- BLANK_LEADING, 1, 1 = blank leading zero digits (digit 0 always lit); 0 = show all digits
- clk  in  1  system clock; the divider runs on this same clock
- clr  in  1  reset, active-low, asynchronous (clear while clr = 0)
- tick_in  in  1  slow square wave from the divider; only its rising edges matter; may be asynchronous to clk
- value  in  4*DIGITS  hex nibbles; nibble i drives digit i; digit 0 is rightmost
- dp_in  in  DIGITS  decimal-point request per digit, 1 = lit
- load  in  1  one-cycle request to display value/dp_in
- load_ack  out  1  one-cycle pulse when the held request is committed to the display
- an  out  DIGITS  anode enables, active-low, one-hot-low when active
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal-point cathode, active-low

## Operation
- tick_in passes through a 2-flop synchronizer s1→s2, then a history flop s3. The internal strobe is step = s2 & ~s3, one clk wide per tick_in rising edge.
- State:
  - idx: digit index, reset DIGITS-1
  - active: reset 0
  - disp / disp_dp: the shown value, reset 0
  - hold / hold_dp: the captured request
  - pending: reset 0
- On each step:
  - active <= 1.
  - idx <= (idx == DIGITS-1) ? 0 : idx+1.
  - The wrap to 0 is a frame boundary.
- Load path:
  - load captures value/dp_in into hold and sets pending.
  - A load while pending overwrites hold. Latest value wins, and only one ack is produced.
- Commit happens on a frame-boundary step with pending = 1:
  - disp <= hold; pending <= 0; load_ack pulses the following cycle.
  - If load and a frame-boundary step occur in the same cycle, the incoming value/dp_in is committed directly. load_ack still pulses and pending stays 0.
- Outputs are registered and updated only on step or reset:
  - an = active ? ~(1 << idx) : all 1s.
  - seg = hex decode of nibble idx of disp (the committed value after the update).
  - dp = ~disp_dp[idx].
- Hex decode, {g..a} active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Blanking (BLANK_LEADING = 1): digit i > 0 is blanked (seg = 1111111) when nibbles i..DIGITS-1 of disp are all zero. dp is still driven from disp_dp.
- Reset (clr = 0), asynchronous, applies to all flops:
  - an = all 1s, seg = 1111111, dp = 1, load_ack = 0.
  - Synchronizer flops cleared.
  - A mid-frame reset discards pending and hold.
- tick_in held high through reset release produces exactly one step.

## Timing
- tick_in first sampled high at clk edge k (into s1). step is high during the cycle after edge k+1. an/seg/dp change at edge k+2.
- Each digit is lit for one full tick_in period. The frame period is DIGITS tick_in periods.
- load → load_ack latency is at most DIGITS tick_in periods plus 1 clk. It is exactly 1 clk when load coincides with a frame-boundary step.
- load_ack is never high in two consecutive cycles.
- an never has more than one bit low.
- Before the first step after reset, all digits are off.

## Test plan
- Reset then idle: hold clr = 0 with tick_in toggling. Outputs stay an = 1111, seg = 1111111, dp = 1, load_ack = 0. Release clr; the first tick_in rise gives an = 1110 with seg = 1000000 (disp = 0) three edges after sampling.
- Scan order and wrap, DIGITS = 4: eight tick_in rises give an sequence 1110, 1101, 1011, 0111, 1110, 1101, 1011, 0111.
- Commit on frame boundary:
  - At idx = 1, load value = 16'h12AF. No ack occurs until the step to idx 0; load_ack then pulses once.
  - Next frame shows digit0 = 0001110 (F), digit1 = 0001000 (A), digit2 = 0100100 (2), digit3 = 1111001 (1).
- Overwrite while pending: load 16'h1111, then load 16'h0042 before the boundary. Exactly one load_ack; the display shows 0042. With BLANK_LEADING = 1, digits 2 and 3 show seg = 1111111.
- Coincident load and boundary step: load 16'h8888 in the same cycle as the wrap step. load_ack on the next cycle, and digit 0 shows 0000000 immediately.
- Mid-frame reset: set pending (load 16'hBEEF), then pulse clr low for 3 cycles before the boundary. All outputs go to reset values asynchronously, no load_ack follows, and subsequent frames show 0000.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan
// Multiplexed common-anode seven-segment display driver. It steps one digit
// per rising edge of the slow tick_in square wave. It shows a hex value that
// is committed through a load/ack handshake. Commits happen only at frame
// boundaries (the wrap back to digit 0), so a number never tears on screen.
//
// Parameters:
//   DIGITS        number of display digits (2..8)
//   BLANK_LEADING 1 = blank leading zero digits (digit 0 always lit)
// Ports:
//   clk       system clock
//   clr       asynchronous active-low reset
//   tick_in   slow square wave, possibly asynchronous; rising edges step
//   value     hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp_in     decimal-point request per digit, 1 = lit
//   load      one-cycle request to display value/dp_in
//   load_ack  one-cycle pulse when the request reaches the display
//   an        anode enables, active-low, at most one low
//   seg       cathodes {g,f,e,d,c,b,a}, active-low
//   dp        decimal-point cathode, active-low
module seg7_scan #(
  parameter int DIGITS        = 4,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  tick_in,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic                  load_ack,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  // Active-low hex font, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic s1, s2, s3;
  logic step;

  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   disp;
  logic [DIGITS-1:0]     disp_dp;
  logic [4*DIGITS-1:0]   hold;
  logic [DIGITS-1:0]     hold_dp;
  logic                  pending;

  logic                  boundary;
  logic                  commit;
  logic [IW-1:0]         idx_next;
  logic [4*DIGITS-1:0]   disp_next;
  logic [DIGITS-1:0]     disp_dp_next;
  logic [DIGITS-1:0]     blank_mask;
  logic                  zero_above;
  logic [3:0]            nib;
  logic [DIGITS-1:0]     an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  // tick_in may be asynchronous: two flops resynchronise it, and the third
  // keeps history so that only a rising edge makes a one-clock step. s3
  // clears on reset, so a tick_in held high through release still gives
  // exactly one step.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step = s2 & ~s3;

  // Next-state view of the display. A commit happens only on the step that
  // wraps to digit 0. A load landing in that same cycle bypasses hold, so
  // the newest value always wins.
  always_comb begin
    boundary     = step && (idx == LAST);
    commit       = boundary && (pending || load);
    idx_next     = (idx == LAST) ? '0 : idx + 1'b1;
    disp_next    = disp;
    disp_dp_next = disp_dp;
    if (commit) begin
      if (load) begin
        disp_next    = value;
        disp_dp_next = dp_in;
      end else begin
        disp_next    = hold;
        disp_dp_next = hold_dp;
      end
    end
  end

  // blank_mask[i] is set when nibble i and every nibble above it are zero.
  // Digit 0 is never blanked.
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (disp_next[4*i +: 4] == 4'h0);
      blank_mask[i] = zero_above;
    end
  end

  // Output values for the digit about to be lit. They are built from the
  // post-commit display, so a new value shows on the first digit of its frame.
  always_comb begin
    nib     = disp_next[{idx_next, 2'b00} +: 4];
    an_next = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_next);
    dp_next = ~disp_dp_next[idx_next];
    if (BLANK_LEADING && blank_mask[idx_next])
      seg_next = 7'b1111111;
    else
      seg_next = hex_decode(nib);
  end

  // Handshake, scan position and registered outputs. The outputs hold
  // all-off until the first step after reset. After that they change only
  // on a step.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      idx      <= LAST;
      disp     <= '0;
      disp_dp  <= '0;
      hold     <= '0;
      hold_dp  <= '0;
      pending  <= 1'b0;
      load_ack <= 1'b0;
      an       <= '1;
      seg      <= 7'b1111111;
      dp       <= 1'b1;
    end else begin
      load_ack <= commit;
      if (commit) begin
        pending <= 1'b0;
      end else if (load) begin
        hold    <= value;
        hold_dp <= dp_in;
        pending <= 1'b1;
      end
      if (step) begin
        idx     <= idx_next;
        disp    <= disp_next;
        disp_dp <= disp_dp_next;
        an      <= an_next;
        seg     <= seg_next;
        dp      <= dp_next;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan
// Directed self-checking bench for seg7_scan with DIGITS = 4 and
// BLANK_LEADING = 1. tick_in rises are driven by hand. Each scenario task
// checks anodes, segments, decimal point and the load_ack pulse count
// against hand-computed values.
module tb_seg7_scan;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        tick_in;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   ack_count = 0;
  logic prev_ack  = 1'b0;
  logic last_ack  = 1'b0;

  seg7_scan #(.DIGITS(DIGITS), .BLANK_LEADING(1'b1)) dut (
    .clk      (clk),
    .clr      (clr),
    .tick_in  (tick_in),
    .value    (value),
    .dp_in    (dp_in),
    .load     (load),
    .load_ack (load_ack),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  // Counts load_ack pulses and flags any pulse wider than one cycle.
  always @(negedge clk) begin
    if (load_ack === 1'b1) begin
      ack_count++;
      n_cmp++;
      if (prev_ack === 1'b1) begin
        n_bad++;
        $display("[TB] FAIL ack_width: load_ack high two cycles running, previous=%b required 0", prev_ack);
      end
    end
    prev_ack = load_ack;
  end

  // One tick_in rise. An optional load is placed in the exact cycle where
  // the resulting step is consumed. load_ack is sampled just after that edge.
  task automatic tick(input bit with_load, input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (with_load) begin
      value = v;
      dp_in = d;
      load  = 1'b1;
    end
    @(posedge clk);
    #1;
    last_ack = load_ack;
    load     = 1'b0;
    tick_in  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic test_reset;
    clr = 1'b0; tick_in = 1'b0; value = '0; dp_in = '0; load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tick_in = ~tick_in;
      n_cmp++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || load_ack !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL reset_idle: an=%b seg=%b dp=%b ack=%b required 1111 1111111 1 0", an, seg, dp, load_ack);
      end
    end
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    // First rise: no change at edges k and k+1, then digit 0 lit at k+2.
    tick_in = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (e < 2) begin
        if (an !== 4'b1111) begin
          n_bad++;
          $display("[TB] FAIL first_step_early: edge %0d an=%b required 1111", e, an);
        end
      end else begin
        if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL first_step: an=%b seg=%b dp=%b required 1110 1000000 1", an, seg, dp);
        end
      end
    end
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_scan;
    logic [3:0] exp_an  [8];
    logic [6:0] exp_seg [8];
    exp_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    exp_seg = '{7'h7F, 7'h7F, 7'h7F, 7'b1000000, 7'h7F, 7'h7F, 7'h7F, 7'b1000000};
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, '0, '0);
      n_cmp++;
      if (an !== exp_an[i] || seg !== exp_seg[i]) begin
        n_bad++;
        $display("[TB] FAIL scan_%0d: an=%b seg=%b required %b %b", i, an, seg, exp_an[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_commit;
    int a0;
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];
    exp_seg = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tick(1'b0, '0, '0);
    do_load(16'h12AF, 4'b0100);
    a0 = ack_count;
    for (int i = 2; i < 4; i++) begin
      tick(1'b0, '0, '0);
      n_cmp++;
      if (ack_count !== a0 || seg !== 7'h7F) begin
        n_bad++;
        $display("[TB] FAIL commit_early_%0d: acks=%0d seg=%b required %0d 1111111", i, ack_count - a0, seg, 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, '0, '0);
      n_cmp++;
      if (seg !== exp_seg[i] || dp !== exp_dp[i] || an !== ~(4'b0001 << i)) begin
        n_bad++;
        $display("[TB] FAIL commit_digit_%0d: an=%b seg=%b dp=%b required seg %b dp %b", i, an, seg, dp, exp_seg[i], exp_dp[i]);
      end
      if (i == 0) begin
        n_cmp++;
        if (last_ack !== 1'b1 || ack_count !== a0 + 1) begin
          n_bad++;
          $display("[TB] FAIL commit_ack: load_ack=%b acks=%0d required 1 and 1", last_ack, ack_count - a0);
        end
      end
    end
  endtask

  task automatic test_overwrite;
    int a0;
    logic [6:0] exp_seg [4];
    exp_seg = '{7'b0100100, 7'b0011001, 7'h7F, 7'h7F};
    a0 = ack_count;
    tick(1'b0, '0, '0);
    do_load(16'h1111, 4'b0000);
    tick(1'b0, '0, '0);
    do_load(16'h0042, 4'b0000);
    tick(1'b0, '0, '0);
    tick(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, '0, '0);
      n_cmp++;
      if (seg !== exp_seg[i]) begin
        n_bad++;
        $display("[TB] FAIL overwrite_digit_%0d: seg=%b required %b", i, seg, exp_seg[i]);
      end
    end
    n_cmp++;
    if (ack_count !== a0 + 1) begin
      n_bad++;
      $display("[TB] FAIL overwrite_acks: acks=%0d required 1", ack_count - a0);
    end
  endtask

  task automatic test_back_to_back;
    int a0;
    a0 = ack_count;
    tick(1'b1, 16'h8888, 4'b0000);
    n_cmp++;
    if (last_ack !== 1'b1 || an !== 4'b1110 || seg !== 7'b0000000) begin
      n_bad++;
      $display("[TB] FAIL coincident: load_ack=%b an=%b seg=%b required 1 1110 0000000", last_ack, an, seg);
    end
    for (int i = 1; i < 5; i++) begin
      tick(1'b0, '0, '0);
      n_cmp++;
      if (seg !== 7'b0000000) begin
        n_bad++;
        $display("[TB] FAIL coincident_digit_%0d: seg=%b required 0000000", i % 4, seg);
      end
    end
    n_cmp++;
    if (ack_count !== a0 + 1) begin
      n_bad++;
      $display("[TB] FAIL coincident_acks: acks=%0d required 1", ack_count - a0);
    end
  endtask

  task automatic test_midframe_reset;
    int a0;
    do_load(16'hBEEF, 4'b1111);
    tick(1'b0, '0, '0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_cmp++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || load_ack !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL async_reset: an=%b seg=%b dp=%b ack=%b required 1111 1111111 1 0", an, seg, dp, load_ack);
    end
    repeat (3) @(negedge clk);
    clr = 1'b1;
    a0 = ack_count;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (an !== 4'b1111) begin
      n_bad++;
      $display("[TB] FAIL reset_dark: an=%b required 1111", an);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, '0, '0);
      n_cmp++;
      if (an !== ~(4'b0001 << (i % 4)) || seg !== ((i % 4 == 0) ? 7'b1000000 : 7'h7F) || dp !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL after_reset_%0d: an=%b seg=%b dp=%b", i, an, seg, dp);
      end
    end
    n_cmp++;
    if (ack_count !== a0) begin
      n_bad++;
      $display("[TB] FAIL reset_no_ack: acks=%0d required 0", ack_count - a0);
    end
  endtask

  task automatic test_tick_high_reset;
    @(negedge clk);
    clr = 1'b0;
    tick_in = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      n_bad++;
      $display("[TB] FAIL high_release: an=%b seg=%b required 1110 1000000", an, seg);
    end
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    tick(1'b0, '0, '0);
    n_cmp++;
    if (an !== 4'b1101) begin
      n_bad++;
      $display("[TB] FAIL high_release_single: an=%b required 1101", an);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_commit();
    test_overwrite();
    test_back_to_back();
    test_midframe_reset();
    test_tick_high_reset();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
